dma_read_m00_axi: RTL and testbench

- AXI4 full read master: the memory-to-fabric counterpart of the DMA write path.
- Fetches fixed-length INCR bursts from PS DDR starting at a software-programmed base address, stepping 1 KB per burst and wrapping inside a programmed span.
- Pushes each returned beat into a downstream FIFO write port.
- Sits on m00_axi_aclk beside the write master and is controlled by the AXI-Lite status block through plain register ports.

---
 rtl/dma_pkg.sv | 24 ++
 rtl/dma_read_m00_axi.sv | 163 ++++++++++++++++
 tb/tb_dma_read_m00_axi.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_pkg.sv
// Shared types and AXI constants for the DMA read master.
package dma_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ADDR   = 3'd1,
    DATA   = 3'd2,
    NEXT   = 3'd3,
    FINISH = 3'd4
  } dma_state_t;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [3:0] AXI_ARCACHE_VAL = 4'b0011;

  // Address step between consecutive bursts.
  function automatic int unsigned bytes_per_burst(input int unsigned burst_len,
                                                  input int unsigned data_width);
    return burst_len * (data_width / 8);
  endfunction

  localparam int unsigned BYTES_PER_BURST = bytes_per_burst(256, 32);

endpackage

// File: rtl/dma_read_m00_axi.sv
// AXI4 read master: fetches fixed-length INCR bursts from a wrapping address
// window and streams every returned beat into a downstream FIFO.
module dma_read_m00_axi
  import dma_pkg::*;
#(
  parameter int C_M_AXI_ID_WIDTH        = 1,
  parameter int C_M_AXI_ADDR_WIDTH      = 32,
  parameter int C_M_AXI_DATA_WIDTH      = 32,
  parameter int C_M_AXI_READ_BURST_LEN  = 256,
  parameter int C_FIFO_WR_DEPTH         = 32768,
  parameter int ADDR_SPAN               = 8192000
) (
  input  logic                                  M_AXI_ACLK,
  input  logic                                  M_AXI_ARESETN,
  output logic [C_M_AXI_ID_WIDTH-1:0]           M_AXI_ARID,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]         M_AXI_ARADDR,
  output logic [7:0]                            M_AXI_ARLEN,
  output logic [2:0]                            M_AXI_ARSIZE,
  output logic [1:0]                            M_AXI_ARBURST,
  output logic                                  M_AXI_ARLOCK,
  output logic [3:0]                            M_AXI_ARCACHE,
  output logic [2:0]                            M_AXI_ARPROT,
  output logic [3:0]                            M_AXI_ARQOS,
  output logic                                  M_AXI_ARVALID,
  input  logic                                  M_AXI_ARREADY,
  input  logic [C_M_AXI_ID_WIDTH-1:0]           M_AXI_RID,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]         M_AXI_RDATA,
  input  logic [1:0]                            M_AXI_RRESP,
  input  logic                                  M_AXI_RLAST,
  input  logic                                  M_AXI_RVALID,
  output logic                                  M_AXI_RREADY,
  input  logic                                  start,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]         base_addr,
  input  logic [31:0]                           num_bursts,
  input  logic                                  abort,
  input  logic [$clog2(C_FIFO_WR_DEPTH):0]      fifo_wr_space,
  output logic                                  fifo_wr_en,
  output logic [C_M_AXI_DATA_WIDTH-1:0]         fifo_din,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  rd_error,
  output logic [31:0]                           bursts_done,
  output logic [2:0]                            dbg_state
);

  localparam int AW      = C_M_AXI_ADDR_WIDTH;
  localparam int LEN     = C_M_AXI_READ_BURST_LEN;
  localparam int BEAT_W  = (LEN > 1) ? $clog2(LEN) : 1;
  localparam int SPACE_W = $clog2(C_FIFO_WR_DEPTH) + 1;

  localparam logic [AW-1:0]      BURST_BYTES = AW'(bytes_per_burst(LEN, C_M_AXI_DATA_WIDTH));
  localparam logic [AW-1:0]      SPAN        = AW'(ADDR_SPAN);
  localparam logic [BEAT_W-1:0]  LAST_BEAT   = BEAT_W'(LEN - 1);
  localparam logic [SPACE_W-1:0] NEED_SPACE  = SPACE_W'(LEN);

  dma_state_t        state, state_nxt;
  logic [AW-1:0]     base_q, offset_q, offset_sum, offset_nxt;
  logic [31:0]       num_q;
  logic [BEAT_W-1:0] beat_cnt;
  logic              ar_hs, r_hs, space_ok, last_burst;
  logic              unused_rid;

  assign M_AXI_ARID    = '0;
  assign M_AXI_ARLEN   = 8'(LEN - 1);
  assign M_AXI_ARSIZE  = 3'($clog2(C_M_AXI_DATA_WIDTH / 8));
  assign M_AXI_ARBURST = AXI_BURST_INCR;
  assign M_AXI_ARLOCK  = 1'b0;
  assign M_AXI_ARCACHE = AXI_ARCACHE_VAL;
  assign M_AXI_ARPROT  = '0;
  assign M_AXI_ARQOS   = '0;
  assign unused_rid    = ^M_AXI_RID;

  // Valid/ready: a transfer happens on any clock edge where both are high; once
  // ARVALID is raised it and ARADDR stay put until that edge.
  assign ar_hs      = M_AXI_ARVALID & M_AXI_ARREADY;
  assign r_hs       = M_AXI_RVALID & M_AXI_RREADY;
  assign space_ok   = (fifo_wr_space >= NEED_SPACE);
  assign last_burst = ((bursts_done + 32'd1) == num_q);

  assign offset_sum = offset_q + BURST_BYTES;
  assign offset_nxt = (offset_sum >= SPAN) ? '0 : offset_sum;

  assign M_AXI_RREADY = (state == DATA);
  assign busy         = (state != IDLE);
  assign done         = (state == FINISH);
  assign dbg_state    = state;

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) state <= IDLE;
    else                state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (start) state_nxt = (num_bursts == 32'd0) ? FINISH : ADDR;
      // Abort is honoured only before the request is raised; a raised ARVALID
      // must complete its handshake.
      ADDR: begin
        if (!M_AXI_ARVALID && abort) state_nxt = FINISH;
        else if (ar_hs)              state_nxt = DATA;
      end
      DATA:   if (r_hs && M_AXI_RLAST) state_nxt = NEXT;
      NEXT:   state_nxt = (last_burst || abort) ? FINISH : ADDR;
      FINISH: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      M_AXI_ARVALID <= 1'b0;
      M_AXI_ARADDR  <= '0;
      fifo_wr_en    <= 1'b0;
      fifo_din      <= '0;
      rd_error      <= 1'b0;
      bursts_done   <= '0;
      base_q        <= '0;
      offset_q      <= '0;
      num_q         <= '0;
      beat_cnt      <= '0;
    end else begin
      fifo_wr_en <= r_hs;
      if (r_hs) fifo_din <= M_AXI_RDATA;
      case (state)
        IDLE: begin
          if (start) begin
            base_q      <= base_addr;
            num_q       <= num_bursts;
            offset_q    <= '0;
            bursts_done <= '0;
            rd_error    <= 1'b0;
          end
        end
        ADDR: begin
          beat_cnt <= '0;
          if (ar_hs) begin
            M_AXI_ARVALID <= 1'b0;
          end else if (!M_AXI_ARVALID && !abort && space_ok) begin
            M_AXI_ARVALID <= 1'b1;
            M_AXI_ARADDR  <= base_q + offset_q;
          end
        end
        DATA: begin
          if (r_hs) begin
            if (M_AXI_RRESP != AXI_RESP_OKAY)              rd_error <= 1'b1;
            if (M_AXI_RLAST && (beat_cnt != LAST_BEAT))    rd_error <= 1'b1;
            if (!M_AXI_RLAST && (beat_cnt == LAST_BEAT))   rd_error <= 1'b1;
            // Counter parks on the last beat so an overlong burst stays flagged.
            if (M_AXI_RLAST)                beat_cnt <= '0;
            else if (beat_cnt != LAST_BEAT) beat_cnt <= beat_cnt + 1'b1;
          end
        end
        NEXT: begin
          bursts_done <= bursts_done + 32'd1;
          offset_q    <= offset_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_read_m00_axi.sv
// Bench for dma_read_m00_axi: random-latency AXI read slave, reference model of
// addresses and data, scoreboard on the FIFO write port.
module tb_dma_read_m00_axi;

  localparam int LEN   = 256;
  localparam int SPAN  = 2048;
  localparam int DEPTH = 32768;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [0:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize, arprot;
  logic [1:0]  arburst;
  logic        arlock;
  logic [3:0]  arcache, arqos;
  logic        arvalid, rready;
  logic        arready = 1'b0;
  logic [0:0]  rid = 1'b0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0;
  logic        rlast = 1'b0, rvalid = 1'b0;
  logic        start = 1'b0, abort = 1'b0;
  logic [31:0] base_addr = '0, num_bursts = '0;
  logic [15:0] fifo_wr_space = 16'd300;
  logic        fifo_wr_en, busy, done, rd_error;
  logic [31:0] fifo_din, bursts_done;
  logic [2:0]  dbg_state;

  dma_read_m00_axi #(
    .C_M_AXI_ID_WIDTH(1), .C_M_AXI_ADDR_WIDTH(32), .C_M_AXI_DATA_WIDTH(32),
    .C_M_AXI_READ_BURST_LEN(LEN), .C_FIFO_WR_DEPTH(DEPTH), .ADDR_SPAN(SPAN)
  ) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
    .M_AXI_ARID(arid), .M_AXI_ARADDR(araddr), .M_AXI_ARLEN(arlen),
    .M_AXI_ARSIZE(arsize), .M_AXI_ARBURST(arburst), .M_AXI_ARLOCK(arlock),
    .M_AXI_ARCACHE(arcache), .M_AXI_ARPROT(arprot), .M_AXI_ARQOS(arqos),
    .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RID(rid), .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp),
    .M_AXI_RLAST(rlast), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready),
    .start(start), .base_addr(base_addr), .num_bursts(num_bursts), .abort(abort),
    .fifo_wr_space(fifo_wr_space), .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din),
    .busy(busy), .done(done), .rd_error(rd_error), .bursts_done(bursts_done),
    .dbg_state(dbg_state)
  );

  // ---------------- checking ----------------
  int checks_total  = 0;
  int checks_passed = 0;

  task automatic check_eq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks_total++;
    if (actual === expected) checks_passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
  endtask

  // ---------------- memory + AXI slave ----------------
  logic [31:0] mem_seed = 32'h1234_5678;
  logic [31:0] err_addr = 32'h0000_0001;
  int          arready_pct = 100;
  int          rvalid_pct  = 100;
  int          slave_last  = LEN - 1;
  logic [31:0] ar_q[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ mem_seed;
  endfunction

  initial begin : slave
    logic        ar_hs_s, r_hs_s, r_last_s;
    logic [31:0] ar_addr_s, a;
    int          r_beat;
    r_beat = 0;
    forever begin
      @(negedge clk);
      ar_hs_s   = arvalid && arready;
      ar_addr_s = araddr;
      r_hs_s    = rvalid && rready;
      r_last_s  = rlast;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        ar_q.delete();
        r_beat  = 0;
        arready = 1'b0;
        rvalid  = 1'b0;
        rlast   = 1'b0;
      end else begin
        if (ar_hs_s) ar_q.push_back(ar_addr_s);
        if (r_hs_s) begin
          if (r_last_s) begin
            void'(ar_q.pop_front());
            r_beat = 0;
          end else begin
            r_beat++;
          end
        end
        arready = (arready_pct >= $urandom_range(1, 100));
        if (rvalid && !r_hs_s) begin
          // hold the pending beat
        end else if (ar_q.size() != 0 && rvalid_pct >= $urandom_range(1, 100)) begin
          a      = ar_q[0] + 32'(4 * r_beat);
          rvalid = 1'b1;
          rdata  = mem_word(a);
          rresp  = (a == err_addr) ? 2'b10 : 2'b00;
          rlast  = (r_beat == slave_last);
        end else begin
          rvalid = 1'b0;
          rlast  = 1'b0;
        end
      end
    end
  end

  // ---------------- scoreboard / monitor ----------------
  logic [31:0] exp_q[$];
  logic [31:0] exp_addr_q[$];
  int wr_cnt = 0, done_cnt = 0, ar_valid_cycles = 0, ar_hs_cnt = 0;

  initial begin : monitor
    logic        prev_stall;
    logic [31:0] prev_addr;
    prev_stall = 1'b0;
    prev_addr  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (fifo_wr_en) begin
          wr_cnt++;
          if (exp_q.size() == 0) check_eq("fifo_unexpected_write", 32'd1, 32'd0);
          else                   check_eq("fifo_din", fifo_din, exp_q.pop_front());
        end
        if (prev_stall) begin
          check_eq("arvalid_hold", 32'(arvalid), 32'd1);
          check_eq("araddr_hold", araddr, prev_addr);
        end
        if (arvalid) begin
          ar_valid_cycles++;
          check_eq("single_outstanding", 32'(ar_q.size()), 32'd0);
        end
        if (arvalid && arready) begin
          ar_hs_cnt++;
          if (exp_addr_q.size() == 0) check_eq("ar_unexpected", 32'd1, 32'd0);
          else                        check_eq("araddr", araddr, exp_addr_q.pop_front());
        end
        prev_stall = arvalid && !arready;
        prev_addr  = araddr;
        if (done) done_cnt++;
      end
    end
  end

  // ---------------- reference model + drivers ----------------
  int done_base, wr_base, ar_base;

  task automatic build_model(input logic [31:0] base, input int n_model);
    logic [31:0] off, a;
    off = '0;
    for (int b = 0; b < n_model; b++) begin
      a = base + off;
      exp_addr_q.push_back(a);
      for (int i = 0; i <= slave_last; i++) exp_q.push_back(mem_word(a + 32'(4 * i)));
      off = off + 32'd1024;
      if (off >= 32'(SPAN)) off = '0;
    end
  endtask

  task automatic xfer_begin(input logic [31:0] base, input logic [31:0] n, input int n_model);
    build_model(base, n_model);
    done_base = done_cnt;
    wr_base   = wr_cnt;
    ar_base   = ar_hs_cnt;
    @(posedge clk);
    #1;
    start      = 1'b1;
    base_addr  = base;
    num_bursts = n;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic xfer_end(input logic [31:0] exp_bursts, input logic [31:0] exp_err);
    int t;
    t = 0;
    while (done_cnt == done_base && t < 1000 * (int'(exp_bursts) + 1)) begin
      @(negedge clk);
      t++;
    end
    check_eq("done_seen", 32'(done_cnt != done_base), 32'd1);
    repeat (3) @(negedge clk);
    check_eq("done_pulses", 32'(done_cnt - done_base), 32'd1);
    check_eq("bursts_done", bursts_done, exp_bursts);
    check_eq("rd_error", 32'(rd_error), exp_err);
    check_eq("busy_idle", 32'(busy), 32'd0);
    check_eq("data_left", 32'(exp_q.size()), 32'd0);
    check_eq("addr_left", 32'(exp_addr_q.size()), 32'd0);
    exp_q.delete();
    exp_addr_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_arvalid"}, 32'(arvalid), 32'd0);
    check_eq({tag, "_rready"}, 32'(rready), 32'd0);
    check_eq({tag, "_araddr"}, araddr, 32'd0);
    check_eq({tag, "_fifo_wr_en"}, 32'(fifo_wr_en), 32'd0);
    check_eq({tag, "_fifo_din"}, fifo_din, 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_done"}, 32'(done), 32'd0);
    check_eq({tag, "_rd_error"}, 32'(rd_error), 32'd0);
    check_eq({tag, "_bursts_done"}, bursts_done, 32'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin : test
    int t, lat, arv0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    check_eq("arlen", 32'(arlen), 32'd255);
    check_eq("arsize", 32'(arsize), 32'd2);
    check_eq("arburst", 32'(arburst), 32'd1);
    check_eq("arcache", 32'(arcache), 32'd3);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // two back-to-back bursts, always-ready slave
    xfer_begin(32'h1000_0000, 32'd2, 2);
    xfer_end(32'd2, 32'd0);

    // no request until the FIFO has room for a whole burst
    fifo_wr_space = 16'd100;
    xfer_begin(32'h2000_0000, 32'd1, 1);
    arv0 = ar_valid_cycles;
    repeat (50) @(negedge clk);
    check_eq("ar_wait_space", 32'(ar_valid_cycles - arv0), 32'd0);
    fifo_wr_space = 16'd300;
    xfer_end(32'd1, 32'd0);

    // offset wraps on the third burst; slow slave
    arready_pct = 60;
    rvalid_pct  = 70;
    xfer_begin(32'h3000_0000, 32'd3, 3);
    xfer_end(32'd3, 32'd0);

    // SLVERR on beat 17 is sticky, then cleared by the next start
    err_addr = 32'h4000_0000 + 32'd68;
    xfer_begin(32'h4000_0000, 32'd1, 1);
    xfer_end(32'd1, 32'd1);
    check_eq("err_beats_written", 32'(wr_cnt - wr_base), 32'd256);
    err_addr = 32'h0000_0001;
    xfer_begin(32'h4000_0400, 32'd1, 1);
    @(negedge clk);
    check_eq("rd_error_cleared", 32'(rd_error), 32'd0);
    xfer_end(32'd1, 32'd0);

    // abort during the first of five bursts
    xfer_begin(32'h5000_0000, 32'd5, 1);
    t = 0;
    while (ar_hs_cnt == ar_base && t < 200) begin
      @(negedge clk);
      t++;
    end
    check_eq("abort_first_ar", 32'(ar_hs_cnt - ar_base), 32'd1);
    abort = 1'b1;
    xfer_end(32'd1, 32'd0);
    check_eq("abort_no_more_ar", 32'(ar_hs_cnt - ar_base), 32'd1);
    abort = 1'b0;

    // zero bursts: immediate done, no request
    arv0 = ar_valid_cycles;
    xfer_begin(32'h6000_0000, 32'd0, 0);
    lat = 0;
    while (done_cnt == done_base && lat < 4) begin
      @(negedge clk);
      lat++;
    end
    check_eq("zero_done_latency", 32'(lat <= 2), 32'd1);
    xfer_end(32'd0, 32'd0);
    check_eq("zero_no_arvalid", 32'(ar_valid_cycles - arv0), 32'd0);

    // early RLAST on every burst flags an error but each burst still ends there
    slave_last = 99;
    xfer_begin(32'h7000_0000, 32'd2, 2);
    xfer_end(32'd2, 32'd1);
    slave_last = LEN - 1;

    // asynchronous reset in the middle of a data phase
    arready_pct = 100;
    rvalid_pct  = 100;
    xfer_begin(32'h8000_0000, 32'd2, 2);
    t = 0;
    while (wr_cnt < wr_base + 20 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check_eq("pre_reset_busy", 32'(busy), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    exp_q.delete();
    exp_addr_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("post_reset_idle", 32'(busy), 32'd0);

    // randomized transfers
    for (int k = 0; k < 4; k++) begin
      arready_pct = $urandom_range(30, 100);
      rvalid_pct  = $urandom_range(30, 100);
      mem_seed    = $urandom;
      t           = $urandom_range(1, 4);
      xfer_begin($urandom & 32'hFFFF_FC00, 32'(t), t);
      xfer_end(32'(t), 32'd0);
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
